// File: rtl/ddr_rd_wc_fifo.sv
// ddr_rd_wc_fifo: wide-write, narrow-read synchronous FIFO that reads each wide word out as RATIO lanes
module ddr_rd_wc_fifo #(
    parameter int WR_DATA_WIDTH = 256,
    parameter int RATIO = 4,
    parameter int WR_DEPTH_WIDTH = 9,
    parameter int ALMOST_FULL_NUM = 384,
    parameter int ALMOST_EMPTY_NUM = 4,
    localparam int RATIO_LOG = $clog2(RATIO),
    localparam int RD_DATA_WIDTH = WR_DATA_WIDTH / RATIO,
    localparam int RD_DEPTH_WIDTH = WR_DEPTH_WIDTH + RATIO_LOG
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [WR_DATA_WIDTH-1:0]  wr_data,
    output logic                      wr_full,
    output logic                      almost_full,
    output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
    output logic                      wr_overflow,
    input  logic                      rd_en,
    output logic [RD_DATA_WIDTH-1:0]  rd_data,
    output logic                      rd_valid,
    output logic                      rd_empty,
    output logic                      almost_empty,
    output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
    output logic                      rd_underflow
);
    logic [WR_DEPTH_WIDTH:0] wr_ptr;
    logic [RD_DEPTH_WIDTH:0] rd_ptr;
    logic [WR_DATA_WIDTH-1:0] mem [2**WR_DEPTH_WIDTH];
    logic [WR_DATA_WIDTH-1:0] ram_q;
    logic [RATIO_LOG:0] lane_q;
    logic wr_ok, rd_ok;

    assign wr_ok = wr_en && !wr_full && !rst;
    assign rd_ok = rd_en && !rd_empty && !rst;
    // a partly read wide word keeps its slot until its last lane is consumed
    assign wr_water_level = wr_ptr - rd_ptr[RD_DEPTH_WIDTH:RATIO_LOG];
    assign rd_water_level = ((RD_DEPTH_WIDTH+1)'(wr_ptr) << RATIO_LOG) - rd_ptr;
    assign wr_full = wr_water_level == {1'b1, {WR_DEPTH_WIDTH{1'b0}}};
    assign rd_empty = rd_water_level == '0;
    assign almost_full = 32'(wr_water_level) >= ALMOST_FULL_NUM;
    assign almost_empty = 32'(rd_water_level) <= ALMOST_EMPTY_NUM;
    assign rd_data = RD_DATA_WIDTH'(ram_q >> (32'(lane_q) * RD_DATA_WIDTH));

    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr[WR_DEPTH_WIDTH-1:0]] <= wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rd_valid <= 1'b0;
            wr_overflow <= 1'b0;
            rd_underflow <= 1'b0;
            ram_q <= '0;
            lane_q <= '0;
        end else begin
            wr_ptr <= wr_ptr + (WR_DEPTH_WIDTH+1)'(wr_ok);
            rd_ptr <= rd_ptr + (RD_DEPTH_WIDTH+1)'(rd_ok);
            rd_valid <= rd_ok;
            wr_overflow <= wr_en && wr_full;
            rd_underflow <= rd_en && rd_empty;
            if (rd_ok) begin
                ram_q <= mem[rd_ptr[RD_DEPTH_WIDTH-1:RATIO_LOG]];
                lane_q <= (RATIO_LOG+1)'(rd_ptr % RATIO);
            end
        end
    end
endmodule

// File: tb/tb_ddr_rd_wc_fifo.sv
// tb_ddr_rd_wc_fifo: scoreboard bench for the default build plus RATIO=1 and RATIO=8 builds
module tb_ddr_rd_wc_fifo;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic wr_en = 0, rd_en = 0;
    logic [255:0] wr_data = '0;
    logic wr_full, almost_full, wr_overflow, rd_valid, rd_empty, almost_empty, rd_underflow;
    logic [9:0] wr_water_level;
    logic [11:0] rd_water_level;
    logic [63:0] rd_data;

    logic r1_wr_en = 0, r1_rd_en = 0;
    logic [63:0] r1_wr_data = '0, r1_rd_data;
    logic r1_wr_full, r1_almost_full, r1_wr_overflow, r1_rd_valid, r1_rd_empty, r1_almost_empty, r1_rd_underflow;
    logic [4:0] r1_wr_water_level, r1_rd_water_level;

    logic r8_wr_en = 0, r8_rd_en = 0;
    logic [255:0] r8_wr_data = '0;
    logic [31:0] r8_rd_data;
    logic r8_wr_full, r8_almost_full, r8_wr_overflow, r8_rd_valid, r8_rd_empty, r8_almost_empty, r8_rd_underflow;
    logic [4:0] r8_wr_water_level;
    logic [7:0] r8_rd_water_level;

    int passed = 0, total = 0;
    logic [63:0] q[$];
    localparam logic [63:0] LANE_A = 64'hAAAA_AAAA_AAAA_AAAA, LANE_B = 64'hBBBB_BBBB_BBBB_BBBB;
    localparam logic [63:0] LANE_C = 64'hCCCC_CCCC_CCCC_CCCC, LANE_D = 64'hDDDD_DDDD_DDDD_DDDD;

    ddr_rd_wc_fifo dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
        .almost_full(almost_full), .wr_water_level(wr_water_level), .wr_overflow(wr_overflow),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rd_empty(rd_empty),
        .almost_empty(almost_empty), .rd_water_level(rd_water_level), .rd_underflow(rd_underflow)
    );

    ddr_rd_wc_fifo #(.WR_DATA_WIDTH(64), .RATIO(1), .WR_DEPTH_WIDTH(4), .ALMOST_FULL_NUM(12)) dut_r1 (
        .clk(clk), .rst(rst), .wr_en(r1_wr_en), .wr_data(r1_wr_data), .wr_full(r1_wr_full),
        .almost_full(r1_almost_full), .wr_water_level(r1_wr_water_level), .wr_overflow(r1_wr_overflow),
        .rd_en(r1_rd_en), .rd_data(r1_rd_data), .rd_valid(r1_rd_valid), .rd_empty(r1_rd_empty),
        .almost_empty(r1_almost_empty), .rd_water_level(r1_rd_water_level), .rd_underflow(r1_rd_underflow)
    );

    ddr_rd_wc_fifo #(.WR_DATA_WIDTH(256), .RATIO(8), .WR_DEPTH_WIDTH(4), .ALMOST_FULL_NUM(12)) dut_r8 (
        .clk(clk), .rst(rst), .wr_en(r8_wr_en), .wr_data(r8_wr_data), .wr_full(r8_wr_full),
        .almost_full(r8_almost_full), .wr_water_level(r8_wr_water_level), .wr_overflow(r8_wr_overflow),
        .rd_en(r8_rd_en), .rd_data(r8_rd_data), .rd_valid(r8_rd_valid), .rd_empty(r8_rd_empty),
        .almost_empty(r8_almost_empty), .rd_water_level(r8_rd_water_level), .rd_underflow(r8_rd_underflow)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1;
        tick();
        tick();
        total++;
        if ({rd_empty, almost_empty, wr_full, almost_full, rd_valid, wr_overflow, rd_underflow} !== 7'b1100000)
            $display("FAIL reset_flags got %b want 1100000", {rd_empty, almost_empty, wr_full, almost_full, rd_valid, wr_overflow, rd_underflow});
        else passed++;
        total++;
        if (wr_water_level !== 10'd0 || rd_water_level !== 12'd0)
            $display("FAIL reset_levels got wr=%0d rd=%0d want 0/0", wr_water_level, rd_water_level);
        else passed++;
        total++;
        if (rd_data !== 64'd0) $display("FAIL reset_rd_data got %h want 0", rd_data);
        else passed++;
        total++;
        if ({r1_rd_empty, r1_wr_full, r1_rd_valid, r8_rd_empty, r8_wr_full, r8_rd_valid} !== 6'b100100)
            $display("FAIL reset_variants got %b want 100100", {r1_rd_empty, r1_wr_full, r1_rd_valid, r8_rd_empty, r8_wr_full, r8_rd_valid});
        else passed++;
        rst = 0;
    endtask

    task automatic test_lanes;
        wr_data = '0;
        wr_data[63:0] = LANE_A;
        wr_data[127:64] = LANE_B;
        wr_data[191:128] = LANE_C;
        wr_data[255:192] = LANE_D;
        q.push_back(LANE_A); q.push_back(LANE_B); q.push_back(LANE_C); q.push_back(LANE_D);
        wr_en = 1;
        tick();
        wr_en = 0;
        total++;
        if (rd_water_level !== 12'd4 || wr_water_level !== 10'd1 || rd_empty !== 1'b0)
            $display("FAIL lanes_after_write got rd=%0d wr=%0d empty=%b want 4/1/0", rd_water_level, wr_water_level, rd_empty);
        else passed++;
        rd_en = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) rd_en = 0;
            total++;
            if (rd_valid !== 1'b1 || rd_data !== q[0])
                $display("FAIL lanes_data[%0d] got valid=%b data=%h want 1/%h", i, rd_valid, rd_data, q[0]);
            else passed++;
            void'(q.pop_front());
            total++;
            if (rd_water_level !== 12'(3 - i))
                $display("FAIL lanes_rd_level[%0d] got %0d want %0d", i, rd_water_level, 3 - i);
            else passed++;
            total++;
            if (wr_water_level !== ((i == 3) ? 10'd0 : 10'd1))
                $display("FAIL lanes_wr_level[%0d] got %0d want %0d", i, wr_water_level, (i == 3) ? 0 : 1);
            else passed++;
        end
        total++;
        if (rd_empty !== 1'b1) $display("FAIL lanes_empty got %b want 1", rd_empty);
        else passed++;
        tick();
        total++;
        if (rd_valid !== 1'b0) $display("FAIL lanes_valid_drop got %b want 0", rd_valid);
        else passed++;
    endtask

    task automatic test_underflow;
        rd_en = 1;
        tick();
        rd_en = 0;
        total++;
        if (rd_underflow !== 1'b1 || rd_valid !== 1'b0)
            $display("FAIL underflow_pulse got uf=%b valid=%b want 1/0", rd_underflow, rd_valid);
        else passed++;
        total++;
        if (rd_water_level !== 12'd0 || wr_water_level !== 10'd0 || rd_data !== LANE_D)
            $display("FAIL underflow_hold got rd=%0d wr=%0d data=%h want 0/0/%h", rd_water_level, wr_water_level, rd_data, LANE_D);
        else passed++;
        tick();
        total++;
        if (rd_underflow !== 1'b0) $display("FAIL underflow_single got %b want 0", rd_underflow);
        else passed++;
    endtask

    task automatic test_fill;
        for (int i = 0; i < 512; i++) begin
            for (int k = 0; k < 8; k++) wr_data[k*32 +: 32] = $urandom;
            for (int k = 0; k < 4; k++) q.push_back(wr_data[k*64 +: 64]);
            wr_en = 1;
            tick();
            total++;
            if (almost_full !== (i + 1 >= 384) || wr_full !== (i + 1 == 512))
                $display("FAIL fill_flags[%0d] got af=%b full=%b want %b/%b", i, almost_full, wr_full, i + 1 >= 384, i + 1 == 512);
            else passed++;
        end
        wr_data = '1;
        tick();
        wr_en = 0;
        total++;
        if (wr_overflow !== 1'b1 || wr_water_level !== 10'd512)
            $display("FAIL overflow_pulse got ovf=%b wr=%0d want 1/512", wr_overflow, wr_water_level);
        else passed++;
        tick();
        total++;
        if (wr_overflow !== 1'b0) $display("FAIL overflow_single got %b want 0", wr_overflow);
        else passed++;
    endtask

    task automatic test_full_rw;
        wr_en = 1;
        wr_data = '1;
        rd_en = 1;
        for (int k = 1; k <= 2048; k++) begin
            tick();
            if (k == 2048) rd_en = 0;
            if (k == 1) begin
                wr_en = 0;
                total++;
                if (wr_overflow !== 1'b1 || wr_water_level !== 10'd512 || rd_water_level !== 12'd2047)
                    $display("FAIL full_rw_reject got ovf=%b wr=%0d rd=%0d want 1/512/2047", wr_overflow, wr_water_level, rd_water_level);
                else passed++;
            end
            if (k <= 4) begin
                total++;
                if (wr_full !== (k < 4)) $display("FAIL full_rw_full[%0d] got %b want %b", k, wr_full, k < 4);
                else passed++;
            end
            total++;
            if (rd_valid !== 1'b1 || q.size() == 0 || rd_data !== q[0])
                $display("FAIL drain_data[%0d] got valid=%b data=%h want 1/%h", k, rd_valid, rd_data, (q.size() != 0) ? q[0] : 64'd0);
            else passed++;
            if (q.size() != 0) void'(q.pop_front());
        end
        total++;
        if (rd_empty !== 1'b1 || wr_water_level !== 10'd0)
            $display("FAIL drain_empty got empty=%b wr=%0d want 1/0", rd_empty, wr_water_level);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid;
        wr_en = 1;
        for (int i = 0; i < 26; i++) begin
            for (int k = 0; k < 8; k++) wr_data[k*32 +: 32] = $urandom;
            for (int k = 0; k < 4; k++) q.push_back(wr_data[k*64 +: 64]);
            tick();
        end
        wr_en = 0;
        rd_en = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (rd_valid !== 1'b1 || rd_data !== q[0])
                $display("FAIL burst_data[%0d] got valid=%b data=%h want 1/%h", i, rd_valid, rd_data, q[0]);
            else passed++;
            void'(q.pop_front());
        end
        total++;
        if (rd_water_level !== 12'd100) $display("FAIL burst_level got %0d want 100", rd_water_level);
        else passed++;
        rst = 1;
        wr_en = 1;
        tick();
        total++;
        if ({rd_empty, almost_empty, wr_full, almost_full, rd_valid, wr_overflow, rd_underflow} !== 7'b1100000 ||
            wr_water_level !== 10'd0 || rd_water_level !== 12'd0 || rd_data !== 64'd0)
            $display("FAIL midreset got flags=%b wr=%0d rd=%0d data=%h want 1100000/0/0/0",
                     {rd_empty, almost_empty, wr_full, almost_full, rd_valid, wr_overflow, rd_underflow}, wr_water_level, rd_water_level, rd_data);
        else passed++;
        rst = 0;
        wr_en = 0;
        rd_en = 0;
        q.delete();
        tick();
        total++;
        if (rd_empty !== 1'b1 || rd_valid !== 1'b0 || rd_water_level !== 12'd0)
            $display("FAIL midreset_after got empty=%b valid=%b rd=%0d want 1/0/0", rd_empty, rd_valid, rd_water_level);
        else passed++;
    endtask

    task automatic test_back_to_back_r1;
        int n = 0;
        for (int i = 0; i < 8; i++) begin
            r1_wr_en = (i < 4);
            r1_wr_data = {$urandom, $urandom};
            if (i < 4) q.push_back(r1_wr_data);
            r1_rd_en = (i >= 1 && i < 5);
            tick();
            if (r1_rd_valid) begin
                n++;
                total++;
                if (q.size() == 0 || r1_rd_data !== q[0])
                    $display("FAIL r1_data[%0d] got %h want %h", n, r1_rd_data, (q.size() != 0) ? q[0] : 64'd0);
                else passed++;
                if (q.size() != 0) void'(q.pop_front());
            end
        end
        r1_wr_en = 0;
        total++;
        if (n != 4 || r1_rd_empty !== 1'b1 || r1_rd_water_level !== 5'd0 || r1_wr_water_level !== 5'd0)
            $display("FAIL r1_end got reads=%0d empty=%b rd=%0d wr=%0d want 4/1/0/0", n, r1_rd_empty, r1_rd_water_level, r1_wr_water_level);
        else passed++;
    endtask

    task automatic test_lanes_r8;
        for (int k = 0; k < 8; k++) begin
            r8_wr_data[k*32 +: 32] = 32'h1111_1111 * (k + 1);
            q.push_back(64'(r8_wr_data[k*32 +: 32]));
        end
        r8_wr_en = 1;
        tick();
        r8_wr_en = 0;
        total++;
        if (r8_rd_water_level !== 8'd8 || r8_wr_water_level !== 5'd1)
            $display("FAIL r8_after_write got rd=%0d wr=%0d want 8/1", r8_rd_water_level, r8_wr_water_level);
        else passed++;
        r8_rd_en = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 7) r8_rd_en = 0;
            total++;
            if (r8_rd_valid !== 1'b1 || r8_rd_data !== q[0][31:0] || r8_rd_water_level !== 8'(7 - i))
                $display("FAIL r8_lane[%0d] got valid=%b data=%h rd=%0d want 1/%h/%0d", i, r8_rd_valid, r8_rd_data, r8_rd_water_level, q[0][31:0], 7 - i);
            else passed++;
            void'(q.pop_front());
        end
        total++;
        if (r8_rd_empty !== 1'b1 || r8_wr_water_level !== 5'd0)
            $display("FAIL r8_end got empty=%b wr=%0d want 1/0", r8_rd_empty, r8_wr_water_level);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_lanes();
        test_underflow();
        test_fill();
        test_full_rw();
        test_reset_mid();
        test_back_to_back_r1();
        test_lanes_r8();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
